// File: rtl/stroke_rasterizer_if.sv
// rtl/stroke_rasterizer_if.sv - segment request, status and pixel port bundle for stroke_rasterizer
interface stroke_rasterizer_if #(
    parameter int COLOR_DEPTH = 9
);
    logic                   start;
    logic [8:0]             x0;
    logic [7:0]             y0;
    logic [8:0]             x1;
    logic [7:0]             y1;
    logic [COLOR_DEPTH-1:0] color;
    logic                   busy;
    logic                   done;
    logic [8:0]             vga_x;
    logic [7:0]             vga_y;
    logic [COLOR_DEPTH-1:0] vga_color;
    logic                   vga_write;

    // Issuing logic: requests segments, watches status and the pixel stream
    modport master (
        output start, x0, y0, x1, y1, color,
        input  busy, done, vga_x, vga_y, vga_color, vga_write
    );

    // Rasterizer side
    modport slave (
        input  start, x0, y0, x1, y1, color,
        output busy, done, vga_x, vga_y, vga_color, vga_write
    );
endinterface

// File: rtl/stroke_rasterizer.sv
// rtl/stroke_rasterizer.sv - Bresenham segment rasterizer emitting one pixel write per clock
module stroke_rasterizer #(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 240,
    parameter int COLOR_DEPTH   = 9
) (
    input logic                CLOCK_50,
    input logic                reset,
    stroke_rasterizer_if.slave bus
);
    localparam logic [8:0] X_MAX = 9'(SCREEN_WIDTH - 1);
    localparam logic [7:0] Y_MAX = 8'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

    state_t                  state_q, state_d;
    logic [8:0]              x0_q, x0_d, x1_q, x1_d;
    logic [7:0]              y0_q, y0_d, y1_q, y1_d;
    logic [COLOR_DEPTH-1:0]  color_q, color_d;
    logic signed [11:0]      dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                    sx_q, sx_d, sy_q, sy_d;
    logic [8:0]              cur_x_q, cur_x_d;
    logic [7:0]              cur_y_q, cur_y_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    vga_write_q, vga_write_d;
    logic [COLOR_DEPTH-1:0]  vga_color_q, vga_color_d;

    logic signed [11:0]      diff_x, diff_y, e2, err_n;

    // The current pixel register doubles as the vga coordinate output, so the
    // coordinates naturally hold their last value between segments.
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vga_x     = cur_x_q;
    assign bus.vga_y     = cur_y_q;
    assign bus.vga_color = vga_color_q;
    assign bus.vga_write = vga_write_q;

    // Next-state logic: latch and clamp, derive stepping terms, then walk the line
    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        err_d       = err_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        vga_write_d = 1'b0;
        vga_color_d = vga_color_q;
        diff_x      = 12'sd0;
        diff_y      = 12'sd0;
        e2          = 12'sd0;
        err_n       = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x0_d    = (bus.x0 > X_MAX) ? X_MAX : bus.x0;
                    y0_d    = (bus.y0 > Y_MAX) ? Y_MAX : bus.y0;
                    x1_d    = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
                    y1_d    = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
                    color_d = bus.color;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // First pixel is registered here so writes start the next cycle
                diff_x      = $signed({3'b000, x1_q}) - $signed({3'b000, x0_q});
                diff_y      = $signed({4'b0000, y1_q}) - $signed({4'b0000, y0_q});
                dx_d        = diff_x[11] ? -diff_x : diff_x;
                dy_d        = diff_y[11] ? diff_y : -diff_y;
                sx_d        = (x0_q < x1_q);
                sy_d        = (y0_q < y1_q);
                err_d       = dx_d + dy_d;
                cur_x_d     = x0_q;
                cur_y_d     = y0_q;
                vga_color_d = color_q;
                vga_write_d = 1'b1;
                state_d     = S_DRAW;
            end
            S_DRAW: begin
                if (cur_x_q == x1_q && cur_y_q == y1_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    e2 = err_q <<< 1;
                    if (e2 >= dy_q) begin
                        err_n   = err_n + dy_q;
                        cur_x_d = sx_q ? cur_x_q + 9'd1 : cur_x_q - 9'd1;
                    end
                    if (e2 <= dx_q) begin
                        err_n   = err_n + dx_q;
                        cur_y_d = sy_q ? cur_y_q + 8'd1 : cur_y_q - 8'd1;
                    end
                    err_d       = err_n;
                    vga_write_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            err_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vga_write_q <= 1'b0;
            vga_color_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            err_q       <= err_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vga_write_q <= vga_write_d;
            vga_color_q <= vga_color_d;
        end
    end
endmodule

// File: tb/tb_stroke_rasterizer.sv
// tb/tb_stroke_rasterizer.sv - self-checking bench for stroke_rasterizer
module tb_stroke_rasterizer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    stroke_rasterizer_if #(.COLOR_DEPTH(9)) bus ();

    stroke_rasterizer #(
        .SCREEN_WIDTH (320),
        .SCREEN_HEIGHT(240),
        .COLOR_DEPTH  (9)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int ex[$];
    int ey[$];
    int cap_x[$];
    int cap_y[$];

    function automatic int clamp_x(input int v);
        return (v > 319) ? 319 : v;
    endfunction

    function automatic int clamp_y(input int v);
        return (v > 239) ? 239 : v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: textbook integer Bresenham walk on clamped endpoints
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, tx, ty, dx, dy, sx, sy, err, e2;
        ex.delete();
        ey.delete();
        x  = clamp_x(ax0);
        y  = clamp_y(ay0);
        tx = clamp_x(ax1);
        ty = clamp_y(ay1);
        dx = iabs(tx - x);
        dy = -iabs(ty - y);
        sx = (x < tx) ? 1 : -1;
        sy = (y < ty) ? 1 : -1;
        err = dx + dy;
        while (ex.size() < 1000) begin
            ex.push_back(x);
            ey.push_back(y);
            if (x == tx && y == ty) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Issues one segment (start already low, called at a negedge) and checks the
    // whole timeline; returns at the negedge of the done cycle.
    task automatic expect_segment(input int ax0, input int ay0, input int ax1, input int ay1,
                                  input logic [8:0] col, input int pulse_at, input string name);
        int n, want_cnt, wr_cnt;
        logic exp_busy, exp_wr, exp_done;
        build_model(ax0, ay0, ax1, ay1);
        n = ex.size();
        want_cnt = ((iabs(clamp_x(ax1) - clamp_x(ax0)) > iabs(clamp_y(ay1) - clamp_y(ay0)))
                    ? iabs(clamp_x(ax1) - clamp_x(ax0)) : iabs(clamp_y(ay1) - clamp_y(ay0))) + 1;
        wr_cnt = 0;
        cap_x.delete();
        cap_y.delete();
        bus.x0 = 9'(ax0);
        bus.y0 = 8'(ay0);
        bus.x1 = 9'(ax1);
        bus.y1 = 8'(ay1);
        bus.color = col;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            exp_busy = (c <= n + 1);
            exp_wr   = (c >= 2 && c <= n + 1);
            exp_done = (c == n + 2);
            n_cmp++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy cycle=%0d got=%b want=%b", name, c, bus.busy, exp_busy);
            end
            n_cmp++;
            if (bus.vga_write !== exp_wr) begin
                n_fail++;
                $display("FAIL %s vga_write cycle=%0d got=%b want=%b", name, c, bus.vga_write, exp_wr);
            end
            n_cmp++;
            if (bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL %s done cycle=%0d got=%b want=%b", name, c, bus.done, exp_done);
            end
            if (bus.vga_write === 1'b1) begin
                wr_cnt++;
                cap_x.push_back(int'(bus.vga_x));
                cap_y.push_back(int'(bus.vga_y));
            end
            if (exp_wr) begin
                n_cmp++;
                if (bus.vga_x !== 9'(ex[c-2]) || bus.vga_y !== 8'(ey[c-2]) || bus.vga_color !== col) begin
                    n_fail++;
                    $display("FAIL %s pixel idx=%0d got=(%0d,%0d,%h) want=(%0d,%0d,%h)",
                             name, c - 2, bus.vga_x, bus.vga_y, bus.vga_color, ex[c-2], ey[c-2], col);
                end
            end
            // Inputs after acceptance must not disturb the segment
            if (c == 1) begin
                bus.start = 1'b0;
                bus.x0 = 9'($urandom);
                bus.y0 = 8'($urandom);
                bus.x1 = 9'($urandom);
                bus.y1 = 8'($urandom);
                bus.color = 9'($urandom);
            end
            if (pulse_at != 0 && c == pulse_at) bus.start = 1'b1;
            if (c == pulse_at + 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        n_cmp++;
        if (wr_cnt !== want_cnt) begin
            n_fail++;
            $display("FAIL %s write_count got=%0d want=%0d", name, wr_cnt, want_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.x0 = 9'd33; bus.y0 = 8'd44; bus.x1 = 9'd55; bus.y1 = 8'd66; bus.color = 9'h155;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.vga_write} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.vga_write});
        end
        n_cmp++;
        if (bus.vga_x !== 9'd0 || bus.vga_y !== 8'd0 || bus.vga_color !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_pixel got=(%0d,%0d,%h) want=(0,0,0)", bus.vga_x, bus.vga_y, bus.vga_color);
        end
        bus.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_point();
        expect_segment(10, 20, 10, 20, 9'h1FF, 0, "point");
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        expect_segment(0, 0, 5, 0, 9'h0A5, 0, "horizontal");
        @(negedge clk);
    endtask

    task automatic test_steep_negative();
        int bad;
        expect_segment(100, 100, 98, 95, 9'h123, 0, "steep_neg");
        bad = 0;
        for (int i = 1; i < cap_x.size(); i++)
            if (cap_x[i] > cap_x[i-1] || cap_y[i] != cap_y[i-1] - 1) bad++;
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL steep_neg_monotonic got=%0d bad_steps want=0", bad);
        end
        @(negedge clk);
    endtask

    task automatic test_full_diagonal();
        int bad;
        expect_segment(319, 239, 0, 0, 9'h0F0, 0, "full_diag");
        bad = 0;
        for (int i = 0; i < cap_x.size(); i++) begin
            if (cap_x[i] > 319 || cap_y[i] > 239) bad++;
            if (i > 0 && (iabs(cap_x[i] - cap_x[i-1]) > 1 || iabs(cap_y[i] - cap_y[i-1]) > 1)) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL full_diag_connectivity got=%0d bad want=0", bad);
        end
        n_cmp++;
        if (cap_x.size() == 0 || cap_x[cap_x.size()-1] != 0 || cap_y[cap_y.size()-1] != 0) begin
            n_fail++;
            $display("FAIL full_diag_endpoint got_writes=%0d want last=(0,0)", cap_x.size());
        end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        expect_segment(400, 250, 319, 239, 9'h007, 0, "clamp");
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        expect_segment(10, 10, 29, 15, 9'h1C3, 6, "start_ignored");
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.busy, bus.vga_write, bus.done} !== 3'b000) begin
                n_fail++;
                $display("FAIL start_ignored_after got=%b want=000", {bus.busy, bus.vga_write, bus.done});
            end
        end
    endtask

    task automatic test_reset_abort();
        build_model(10, 10, 29, 15);
        bus.x0 = 9'd10; bus.y0 = 8'd10; bus.x1 = 9'd29; bus.y1 = 8'd15; bus.color = 9'h0AA;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_cmp++;
        if (bus.vga_write !== 1'b1 || bus.vga_x !== 9'(ex[4]) || bus.vga_y !== 8'(ey[4])) begin
            n_fail++;
            $display("FAIL abort_fifth_write got=(%b,%0d,%0d) want=(1,%0d,%0d)",
                     bus.vga_write, bus.vga_x, bus.vga_y, ex[4], ey[4]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({bus.vga_write, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_after_reset got=%b want=000", {bus.vga_write, bus.busy, bus.done});
        end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.vga_write, bus.busy, bus.done} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_quiet got=%b want=000", {bus.vga_write, bus.busy, bus.done});
            end
        end
        expect_segment(50, 60, 40, 66, 9'h111, 0, "after_abort");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        expect_segment(5, 5, 12, 9, 9'h042, 0, "b2b_a");
        expect_segment(200, 100, 190, 130, 9'h099, 0, "b2b_b");
        expect_segment(7, 7, 7, 7, 9'h100, 0, "b2b_c");
        @(negedge clk);
    endtask

    task automatic test_random();
        int ax0, ay0, ax1, ay1;
        for (int i = 0; i < 16; i++) begin
            ax0 = int'($urandom_range(0, 511));
            ay0 = int'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                ax1 = clamp_x(ax0) + int'($urandom_range(0, 40)) - 20;
                ay1 = clamp_y(ay0) + int'($urandom_range(0, 40)) - 20;
                if (ax1 < 0) ax1 = 0;
                if (ay1 < 0) ay1 = 0;
            end else begin
                ax1 = int'($urandom_range(0, 511));
                ay1 = int'($urandom_range(0, 255));
            end
            expect_segment(ax0, ay0, ax1, ay1, 9'($urandom), 0, "random");
            if (i % 3 == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.color = '0;
        @(negedge clk);
        test_reset();
        test_point();
        test_horizontal();
        test_steep_negative();
        test_full_diagonal();
        test_clamp();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
